// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-stationary systolic array sequencer.
// Loads a weight tile (LOAD_W), streams N skewed activation vectors
// (COMPUTE), then flushes the array (DRAIN) and pulses done.
// Ports: clk, reset (async, active-low), start/n_vec/reuse_w job request;
// busy/done status; w_rd_*/a_rd_* buffer reads; top_sel, pe_mux_ctrl,
// pe_weight_we PE controls; act_valid per row, res_valid per column.
// Optional: SA_CTRL_WREUSE_EN enables reuse_w (skip weight load).
module systolic_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VEC_W-1:0]        n_vec,
  input  logic                    reuse_w,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [$clog2(ROWS)-1:0] w_rd_addr,
  output logic                    a_rd_en,
  output logic [VEC_W-1:0]        a_rd_addr,
  output logic                    top_sel,
  output logic                    pe_mux_ctrl,
  output logic                    pe_weight_we,
  output logic [ROWS-1:0]         act_valid,
  output logic [COLS-1:0]         res_valid
);

  localparam int AW = $clog2(ROWS);
  // t reaches N+ROWS+COLS-2 at most; one spare bit keeps it wrap-free
  localparam int TW = VEC_W + $clog2(ROWS + COLS) + 1;
  localparam logic [TW-1:0] LAST_LOAD  = TW'(ROWS - 1);
  localparam logic [TW-1:0] DRAIN_SPAN = TW'(ROWS + COLS - 2);
  localparam logic [TW-1:0] ONE        = TW'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, COMPUTE, DRAIN, DONE
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    t, t_nx;
  logic [VEC_W-1:0] n_q, n_nx;
  logic [TW-1:0]    n_ext;
  logic             use_reuse;

  assign n_ext = TW'(n_q);

`ifdef SA_CTRL_WREUSE_EN
  assign use_reuse = reuse_w;
`else
  logic unused_reuse_w;
  assign use_reuse      = 1'b0;
  assign unused_reuse_w = reuse_w;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      t     <= '0;
      n_q   <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      n_q   <= n_nx;
    end
  end

  always_comb begin
    state_nx = state;
    t_nx     = t;
    n_nx     = n_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          n_nx = n_vec;
          t_nx = '0;
          if (use_reuse) begin
            state_nx = (n_vec == '0) ? DONE : COMPUTE;
          end else begin
            state_nx = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        if (t == LAST_LOAD) begin
          t_nx     = '0;
          state_nx = (n_q == '0) ? DONE : COMPUTE;
        end else begin
          t_nx = t + ONE;
        end
      end
      COMPUTE: begin
        // t runs on into DRAIN so the skew windows stay contiguous
        t_nx = t + ONE;
        if (t == n_ext - ONE) state_nx = DRAIN;
      end
      DRAIN: begin
        if (t == n_ext + DRAIN_SPAN) begin
          t_nx     = '0;
          state_nx = DONE;
        end else begin
          t_nx = t + ONE;
        end
      end
      DONE: begin
        t_nx     = '0;
        state_nx = IDLE;
      end
      default: begin
        t_nx     = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    a_rd_en      = 1'b0;
    a_rd_addr    = '0;
    top_sel      = 1'b0;
    pe_mux_ctrl  = 1'b0;
    pe_weight_we = 1'b0;
    act_valid    = '0;
    res_valid    = '0;
    unique case (state)
      LOAD_W: begin
        // bottom row first so row r holds weight r after ROWS shifts
        w_rd_en      = 1'b1;
        w_rd_addr    = AW'(LAST_LOAD - t);
        top_sel      = 1'b1;
        pe_mux_ctrl  = 1'b1;
        pe_weight_we = (t == LAST_LOAD);
      end
      COMPUTE: begin
        a_rd_en   = 1'b1;
        a_rd_addr = t[VEC_W-1:0];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
    if (state == COMPUTE || state == DRAIN) begin
      for (int r = 0; r < ROWS; r++) begin
        act_valid[r] = (t >= TW'(r)) && (t < TW'(r) + n_ext);
      end
      for (int c = 0; c < COLS; c++) begin
        res_valid[c] = (t >= TW'(ROWS + c)) &&
                       (t < TW'(ROWS + c) + n_ext);
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: self-checking bench for systolic_ctrl (4x4, VEC_W=8).
// Expected per-cycle outputs are queued at job start and checked on negedge.
module tb_systolic_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_vec = 8'd0;
  logic       reuse_w = 1'b0;
  logic       busy, done, w_rd_en, a_rd_en;
  logic       top_sel, pe_mux_ctrl, pe_weight_we;
  logic [1:0] w_rd_addr;
  logic [7:0] a_rd_addr;
  logic [3:0] act_valid, res_valid;

`ifdef SA_CTRL_WREUSE_EN
  localparam bit REUSE_ON = 1'b1;
`else
  localparam bit REUSE_ON = 1'b0;
`endif

  systolic_ctrl #(.ROWS(4), .COLS(4), .VEC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .n_vec(n_vec),
    .reuse_w(reuse_w), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .top_sel(top_sel), .pe_mux_ctrl(pe_mux_ctrl),
    .pe_weight_we(pe_weight_we),
    .act_valid(act_valid), .res_valid(res_valid)
  );

  typedef struct packed {
    logic       busy, done, w_en;
    logic [1:0] w_addr;
    logic       a_en;
    logic [7:0] a_addr;
    logic       top, mux, we;
    logic [3:0] act, res;
  } outs_t;

  typedef struct {
    int    cyc;
    int    e;
    outs_t exp;
    string tag;
  } sb_t;

  sb_t   q[$];
  outs_t tbl[16];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t dut_outs();
    outs_t o;
    o.busy = busy; o.done = done; o.w_en = w_rd_en;
    o.w_addr = w_rd_addr; o.a_en = a_rd_en; o.a_addr = a_rd_addr;
    o.top = top_sel; o.mux = pe_mux_ctrl; o.we = pe_weight_we;
    o.act = act_valid; o.res = res_valid;
    return o;
  endfunction

  function automatic outs_t ld(input logic [1:0] a);
    outs_t o = '0;
    o.busy = 1'b1; o.w_en = 1'b1; o.w_addr = a;
    o.top = 1'b1; o.mux = 1'b1; o.we = (a == 2'd0);
    return o;
  endfunction

  function automatic outs_t cp(input logic ae, input logic [7:0] aa,
                               input logic [3:0] act,
                               input logic [3:0] res);
    outs_t o = '0;
    o.busy = 1'b1; o.a_en = ae; o.a_addr = aa;
    o.act = act; o.res = res;
    return o;
  endfunction

  // expected outputs e cycles after accept, from the timing formulas
  function automatic outs_t gen(input int n, input bit rw, input int e);
    outs_t o = '0;
    int l, t, span;
    l = rw ? 0 : 4;
    span = n + 7;
    if (e < l) return ld(2'(3 - e));
    if (n == 0 && !rw) begin
      if (e == 4) begin o.busy = 1'b1; o.done = 1'b1; end
      return o;
    end
    t = e - l;
    if (t < span) begin
      o.busy = 1'b1;
      if (t < n) begin o.a_en = 1'b1; o.a_addr = 8'(t); end
      for (int r = 0; r < 4; r++) o.act[r] = (t >= r) && (t < r + n);
      for (int c = 0; c < 4; c++)
        o.res[c] = (t >= 4 + c) && (t < 4 + c + n);
    end else if (t == span) begin
      o.busy = 1'b1; o.done = 1'b1;
    end
    return o;
  endfunction

  task automatic push(input int acc, input int e, input outs_t x,
                      input string tag);
    sb_t s;
    s.cyc = acc + e; s.e = e; s.exp = x; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic push_table(input int acc, input int upto,
                            input string tag);
    for (int e = 0; e <= upto; e++) push(acc, e, tbl[e], tag);
  endtask

  task automatic push_job(input int acc, input int n, input bit rw,
                          input string tag);
    int last;
    last = (n == 0 && !rw) ? 5 : (rw ? 0 : 4) + n + 8;
    for (int e = 0; e <= last; e++) push(acc, e, gen(n, rw, e), tag);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL %s e=%0d: sample missed at cycle %0d",
               q[0].tag, q[0].e, cyc);
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      sb_t s;
      s = q.pop_front();
      checks++;
      if (dut_outs() !== s.exp) begin
        errors++;
        $display("FAIL %s e=%0d: actual=%h required=%h",
                 s.tag, s.e, dut_outs(), s.exp);
      end
    end
  end

  task automatic check_now(input string tag, input outs_t want);
    checks++;
    if (dut_outs() !== want) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", tag, dut_outs(), want);
    end
  endtask

  task automatic start_job(input logic [7:0] n, input logic rw,
                           output int acc);
    @(negedge clk);
    start = 1'b1; n_vec = n; reuse_w = rw;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0; n_vec = ~n; reuse_w = ~rw;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (q.size() > 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    #2;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int acc;
    tbl[0]  = ld(2'd3);
    tbl[1]  = ld(2'd2);
    tbl[2]  = ld(2'd1);
    tbl[3]  = ld(2'd0);
    tbl[4]  = cp(1'b1, 8'd0, 4'b0001, 4'b0000);
    tbl[5]  = cp(1'b1, 8'd1, 4'b0011, 4'b0000);
    tbl[6]  = cp(1'b1, 8'd2, 4'b0111, 4'b0000);
    tbl[7]  = cp(1'b0, 8'd0, 4'b1110, 4'b0000);
    tbl[8]  = cp(1'b0, 8'd0, 4'b1100, 4'b0001);
    tbl[9]  = cp(1'b0, 8'd0, 4'b1000, 4'b0011);
    tbl[10] = cp(1'b0, 8'd0, 4'b0000, 4'b0111);
    tbl[11] = cp(1'b0, 8'd0, 4'b0000, 4'b1110);
    tbl[12] = cp(1'b0, 8'd0, 4'b0000, 4'b1100);
    tbl[13] = cp(1'b0, 8'd0, 4'b0000, 4'b1000);
    tbl[14] = '0;
    tbl[14].busy = 1'b1;
    tbl[14].done = 1'b1;
    tbl[15] = '0;

    #1 reset = 1'b0;
    #2 check_now("reset_state", '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // basic job, n_vec scrambled after accept
    start_job(8'd3, 1'b0, acc);
    push_table(acc, 15, "job_n3");
    drain(60);

    // empty job
    start_job(8'd0, 1'b0, acc);
    push_job(acc, 0, 1'b0, "job_n0");
    drain(60);

    // stray start pulses in COMPUTE, then start held through done
    start_job(8'd3, 1'b0, acc);
    push_table(acc, 15, "pulse_a");
    push_table(acc + 16, 15, "pulse_b");
    wait_cyc(acc + 4); start = 1'b1; n_vec = 8'd9;
    wait_cyc(acc + 5); start = 1'b0;
    wait_cyc(acc + 6); start = 1'b1;
    wait_cyc(acc + 7); start = 1'b0; n_vec = 8'd3;
    wait_cyc(acc + 8); start = 1'b1;
    wait_cyc(acc + 16); start = 1'b0; n_vec = 8'd0;
    drain(80);

    // async reset mid-DRAIN
    start_job(8'd3, 1'b0, acc);
    push_table(acc, 9, "pre_abort");
    wait_cyc(acc + 9);
    q.delete();
    reset = 1'b0;
    #1 check_now("async_reset", '0);
    @(negedge clk);
    #1 check_now("reset_held", '0);
    reset = 1'b1;
    start_job(8'd3, 1'b0, acc);
    push_table(acc, 15, "post_abort");
    drain(60);

    // weight reuse (full load when the option is off)
    start_job(8'd2, 1'b1, acc);
    push_job(acc, 2, REUSE_ON, "reuse_n2");
    drain(60);

    // largest vector count
    start_job(8'd255, 1'b0, acc);
    push_job(acc, 255, 1'b0, "job_n255");
    drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for a ROWS×COLS weight-stationary systolic array of processing elements. Per job it streams one weight tile down the array in passthrough mode, latches the weights, then feeds N activation vectors with per-row skew. It also flags when each column's bottom-row output holds a valid result. It sits between the weight/activation buffers and the PE grid, driving every PE's weight-write and mux control.

## Interface
- ROWS, 4, array rows; also the weight-tile depth.
- COLS, 4, array columns.
- VEC_W, 8, width of vector count and activation address.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  job request, sampled in IDLE only.
- n_vec  input  VEC_W  number of activation vectors, latched on accepted start.
- reuse_w  input  1  skip weight load; used only with SA_CTRL_WREUSE_EN.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at job end.
- w_rd_en  output  1  weight buffer read enable.
- w_rd_addr  output  clog2(ROWS)  weight row index.
- a_rd_en  output  1  activation buffer read enable.
- a_rd_addr  output  VEC_W  activation vector index.
- top_sel  output  1  array top-input select: 1 = weight data, 0 = zero (partial-sum seed).
- pe_mux_ctrl  output  1  broadcast to all PEs: 1 = pass in_top down, 0 = accumulate.
- pe_weight_we  output  1  broadcast weight-register write enable.
- act_valid  output  ROWS  bit r: row r left input carries live data this cycle.
- res_valid  output  COLS  bit c: bottom-row out_down of column c holds a result.

## Operation
- Buffers are asynchronous-read: data appears at the array in the same cycle as en/addr.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE. Outputs are decoded from the registered state and the step counter t (Moore).
- IDLE:
  - start=1 latches n_vec and goes to LOAD_W with t=0.
  - With the macro enabled and reuse_w=1, it goes to COMPUTE instead.
- LOAD_W, t=0..ROWS-1:
  - w_rd_en=1, w_rd_addr=ROWS-1-t (bottom row first), top_sel=1, pe_mux_ctrl=1.
  - pe_weight_we=1 only at t=ROWS-1, when row r in_top holds weight row r.
  - Next state is COMPUTE, t=0. If latched n_vec=0, next state is DONE.
- COMPUTE, t=0..N-1, where N is the latched n_vec:
  - a_rd_en=1, a_rd_addr=t, top_sel=0, pe_mux_ctrl=0.
  - Goes to DRAIN at t=N-1.
- DRAIN: a_rd_en=0. t keeps counting from N to N+ROWS+COLS-2, then goes to DONE.
- Across COMPUTE and DRAIN (t is continuous):
  - act_valid[r]=1 iff r ≤ t < r+N.
  - res_valid[c]=1 iff ROWS+c ≤ t < ROWS+c+N.
- DONE: done=1 for one cycle, then IDLE.
- In every state not listed above, all enables, top_sel, pe_mux_ctrl, act_valid and res_valid are 0.
- start outside IDLE is ignored. n_vec changes after acceptance have no effect.
- Counter width is wide enough for VEC_W + ROWS + COLS with no wrap. The n_vec=2^VEC_W-1 case must not overflow.

## Timing
- Reset (asynchronous, reset=0):
  - State returns to IDLE, t=0, latched N=0.
  - Every output is 0: busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, top_sel, pe_mux_ctrl, pe_weight_we, act_valid, res_valid.
  - An aborted job is abandoned; no done is issued.
- Start accepted at edge k: LOAD_W occupies cycles k+1..k+ROWS, and pe_weight_we is high in cycle k+ROWS.
- Job length from accepted start to the done cycle:
  - Full job: ROWS + N + ROWS + COLS − 1 cycles, with done in the last.
  - With weight reuse: N + ROWS + COLS − 1 cycles.
  - n_vec=0: ROWS cycles, then done.
- busy rises the cycle after the accepting edge and falls the cycle after done.
- start held high through DONE launches the next job from IDLE one cycle after done, never in the DONE cycle.

## Configuration
- SA_CTRL_WREUSE_EN defined: reuse_w=1 on start skips LOAD_W. Previously latched PE weights are reused, and pe_weight_we stays 0 for that job.
- SA_CTRL_WREUSE_EN undefined: reuse_w is ignored and every job performs LOAD_W.

## Test plan
- Reset, then ROWS=COLS=4, start with n_vec=3:
  - w_rd_addr reads 3,2,1,0 with pe_mux_ctrl=1, and pe_weight_we is high only with addr 0.
  - a_rd_addr reads 0,1,2.
  - done comes 14 cycles after the accepting edge.
- Same job: act_valid[2] is high at t=2..4. res_valid[3] is high at t=7..9 and is the last high bit. res_valid rises in columns 0→3 on successive cycles.
- n_vec=0: LOAD_W runs 4 cycles, then done; a_rd_en, act_valid and res_valid are never asserted.
- Pulse start twice mid-COMPUTE: the pulses are ignored and the job timing is unchanged. With start held through done, the second job's busy period begins one cycle after done.
- Assert reset mid-DRAIN: all outputs are 0 immediately, with no clock needed. A new start then runs a clean full job.
- Macro defined, reuse_w=1, n_vec=2: no LOAD_W, pe_weight_we is never high, and done comes 9 cycles after accept. With the macro undefined, the same stimulus produces a full LOAD_W.
